// File: rtl/adc_capture_buffer.sv
// Triggered ADC frame capture into a simple dual-port RAM with a two-cycle readout path.
// Capture is armed, waits for an immediate or rising-threshold trigger, then stores consecutive frames.
module adc_capture_buffer #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [16*NUMBER_OF_LINE-1:0] adc_line_in,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trigger_mode,
  input  logic [15:0]                  trigger_level,
  input  logic [DEPTH_LOG2-1:0]        capture_length,
  input  logic [DEPTH_LOG2-1:0]        rd_addr,
  output logic [16*NUMBER_OF_LINE-1:0] rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [DEPTH_LOG2:0]          frame_count,
  output logic [1:0]                   state_dbg
);

  localparam int FW    = 16 * NUMBER_OF_LINE;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2:0]   frame_count_q, frame_count_d;
  logic [DEPTH_LOG2:0]   len_q;
  logic                  mode_q;
  logic                  first_q;
  logic signed [15:0]    prev_q;
  logic                  busy_q, done_q;
  logic [FW-1:0]         ram_q, rd_data_q;
  logic [FW-1:0]         mem [DEPTH];

  logic                  rst_sync_q;
  logic                  arm_pend_q;
  logic                  arm_eff;
  logic                  enter_armed;
  logic                  trig;
  logic                  we;
  logic                  wr_en;
  logic                  last;
  logic [DEPTH_LOG2:0]   fc_inc;
  logic signed [15:0]    sample0;
  logic signed [15:0]    level;

  // Reset asserts everything at once but releases the core on a clock edge.
  // An arm seen while the core is still held is remembered for the following cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 1'b1;
      arm_pend_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b0;
      arm_pend_q <= rst_sync_q & arm & ~abort;
    end
  end

  assign sample0 = $signed(adc_line_in[15:0]);
  assign level   = $signed(trigger_level);
  assign arm_eff = arm | arm_pend_q;
  assign fc_inc  = frame_count_q + ONE;
  assign last    = (fc_inc == len_q);

  // The first armed cycle has no valid previous sample for the crossing test.
  always_comb begin
    trig = 1'b0;
    if (state_q == S_ARMED) begin
      if (mode_q) trig = ~first_q & (sample0 >= level) & (prev_q < level);
      else        trig = first_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    enter_armed   = 1'b0;
    we            = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_eff) begin
            state_d     = S_ARMED;
            enter_armed = 1'b1;
          end
        end
        S_ARMED: begin
          if (trig) begin
            we            = 1'b1;
            frame_count_d = fc_inc;
            state_d       = last ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          we            = 1'b1;
          frame_count_d = fc_inc;
          if (last) state_d = S_DONE;
        end
        S_DONE: begin
          if (arm_eff) begin
            state_d     = S_ARMED;
            enter_armed = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (enter_armed) frame_count_d = '0;
  end

  always_ff @(posedge clock or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q       <= S_IDLE;
      frame_count_q <= '0;
      len_q         <= FULL_LEN;
      mode_q        <= 1'b0;
      first_q       <= 1'b0;
      prev_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      first_q       <= enter_armed;
      prev_q        <= sample0;
      busy_q        <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_q        <= (state_d == S_DONE);
      rd_data_q     <= ram_q;
      if (enter_armed) begin
        mode_q <= trigger_mode;
        len_q  <= (capture_length == '0) ? FULL_LEN : {1'b0, capture_length};
      end
    end
  end

  // Raw reset also gates the write so an edge coinciding with reset stores nothing.
  assign wr_en = we & ~reset & ~rst_sync_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem[frame_count_q[DEPTH_LOG2-1:0]] <= adc_line_in;
    ram_q <= mem[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized bench for adc_capture_buffer: each capture is predicted from the frame
// sequence (trigger index, written window, timeline) and memory is read back through a queue.
module tb_adc_capture_buffer;

  localparam int NL = 4;
  localparam int D  = 4;
  localparam int FW = 16 * NL;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] adc_line_in;
  logic          arm, abort, trigger_mode;
  logic [15:0]   trigger_level;
  logic [D-1:0]  capture_length, rd_addr;
  logic [FW-1:0] rd_data;
  logic          busy, done;
  logic [D:0]    frame_count;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q[$];
  int dir_s0[$];

  adc_capture_buffer #(.NUMBER_OF_LINE(NL), .DEPTH_LOG2(D)) dut (
    .clock(clk), .reset(reset), .adc_line_in(adc_line_in), .arm(arm), .abort(abort),
    .trigger_mode(trigger_mode), .trigger_level(trigger_level),
    .capture_length(capture_length), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input int s0);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[15:0] = 16'(s0);
    return f;
  endfunction

  // abort_rel: cycles after the trigger cycle at which abort (with arm) is pulsed; -1 = none.
  task automatic run_capture(input bit mode, input int lvl, input int len_f,
                             input int abort_rel, input int pre_s0);
    logic [FW-1:0] fr[48];
    int s0[48];
    int t, len, end_c, abort_at, k_last, eff, exp_fc, written;
    bit aborted;
    len = (len_f == 0) ? 16 : len_f;
    for (int i = 0; i < 48; i++)
      s0[i] = (i < dir_s0.size()) ? dir_s0[i] : lvl - 50 + int'($urandom_range(0, 100));
    t = -1;
    if (!mode) t = 0;
    else
      for (int i = 1; i < 48; i++)
        if (t < 0 && s0[i] >= lvl && s0[i-1] < lvl) t = i;
    if (mode && (t < 0 || t + len > 40)) begin
      s0[1] = lvl - 1;
      s0[2] = lvl;
      t = 2;
    end
    for (int i = 0; i < 48; i++) fr[i] = make_frame(s0[i]);
    abort_at = (abort_rel < 0) ? -1 : t + abort_rel;
    end_c    = t + len;
    k_last   = ((abort_at >= 0) ? abort_at + 1 : end_c) + 1;

    @(negedge clk);
    arm = 1'b1; abort = 1'b0; trigger_mode = mode;
    trigger_level = 16'(lvl); capture_length = D'(len_f);
    adc_line_in = make_frame(pre_s0);

    exp_fc = 0;
    for (int k = 0; k <= k_last; k++) begin
      @(negedge clk);
      aborted = (abort_at >= 0) && (k > abort_at);
      eff     = aborted ? abort_at : k;
      exp_fc  = eff - t;
      if (exp_fc < 0) exp_fc = 0;
      if (exp_fc > len) exp_fc = len;
      check("busy", busy, !aborted && k < end_c);
      check("done", done, !aborted && k >= end_c);
      check("frame_count", frame_count, exp_fc);
      adc_line_in    = fr[k];
      abort          = (k == abort_at);
      trigger_mode   = 1'($urandom);
      capture_length = D'($urandom);
      if (k == abort_at)                arm = 1'b1;
      else if (!aborted && k < end_c)   arm = 1'($urandom);
      else                              arm = 1'b0;
    end
    arm = 1'b0; abort = 1'b0;

    written = exp_fc;
    for (int j = 0; j < written + 2; j++) begin
      @(negedge clk);
      if (j >= 2) check("rd_data", rd_data, exp_q.pop_front());
      if (j < written) begin
        rd_addr = D'(j);
        exp_q.push_back(fr[t + j]);
      end
    end
  endtask

  initial begin
    int lvl, len_f, len, rel;
    bit seen;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger_mode = 1'b0;
    trigger_level = '0; capture_length = '0; rd_addr = '0; adc_line_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fc", frame_count, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;

    run_capture(1'b0, 0, 4, -1, 0);
    dir_s0 = '{5, -5, -1, 3, 7};
    run_capture(1'b1, 0, 4, -1, -10);
    dir_s0.delete();
    run_capture(1'b0, 0, 0, -1, 0);
    run_capture(1'b0, 0, 1, -1, 0);
    run_capture(1'b1, 300, 0, -1, 0);
    run_capture(1'b0, 0, 8, 3, 0);

    for (int n = 0; n < 8; n++) begin
      lvl   = int'($urandom_range(0, 2000)) - 1000;
      len_f = int'($urandom_range(0, 15));
      len   = (len_f == 0) ? 16 : len_f;
      rel   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_capture(1'($urandom), lvl, len_f, rel, lvl - 50 + int'($urandom_range(0, 100)));
    end

    // Asynchronous reset between edges during a capture, then arm right after release.
    @(negedge clk);
    arm = 1'b1; trigger_mode = 1'b0; capture_length = D'(8);
    @(negedge clk);
    arm = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_fc", frame_count, 0);
    check("async_rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b0; arm = 1'b1; capture_length = D'(2); trigger_mode = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check("rearm_busy_seen", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("rearm_done_seen", seen, 1);
    check("rearm_fc", frame_count, 2);

    run_capture(1'b0, 0, 5, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
